gpu_scalex_pipe: RTL
====================

// Module: gpu_scalex_pipe
// PURPOSE
//  Parametrised Scale2x/Scale3x pixel engine for the GPU video path, next generation of the Scale2x block.
//  Takes one 3x3 neighbourhood (A..I, E centre) plus a sub-pixel index per beat and returns the expanded sub-pixel.
//  Adds PIX_W generalisation, valid/ready back-pressure, a per-beat mode select and a saturating "edge pixel" statistic.
//  Sits between the line-buffer window generator and the scan-doubler/output FIFO.
// PARAMETERS
//  PIX_W  9   pixel width (palette index or RGB word), 1..24
//  CNT_W  16  width of the edge statistic counter
// PORTS
//  clk         in   1      master clock
//  rst_n       in   1      synchronous reset, active low
//  bypass      in   1      1: output E unchanged (rule disabled)
//  stat_clr    in   1      synchronous clear of stat_cnt
//  ipix_A..I   in   PIX_W  window pixels A B C / D E F / G H I (nine ports)
//  ipix_sel    in   4      sub-pixel index: 0..3 in 2x mode, 0..8 in 3x mode
//  ipix_mode   in   1      0: Scale2x, 1: Scale3x
//  ipix_valid  in   1      input beat valid
//  ipix_ready  out  1      input beat accepted when valid & ready
//  opix_Ex     out  PIX_W  expanded sub-pixel
//  opix_sel    out  4      ipix_sel of the beat, delayed
//  opix_valid  out  1      output beat valid
//  opix_ready  in   1      downstream accepts
//  stat_cnt    out  CNT_W  number of output beats where result != E (saturating)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all pipeline regs, opix_Ex, opix_sel, opix_valid, stat_cnt = 0; ipix_ready=1 next cycle.
//  - 2-stage pipeline: p1 = register window compares + candidate pixels; p2 = select result. Latency 2 cycles when not stalled.
//  - stall = opix_valid & ~opix_ready; ipix_ready = ~stall (combinational); stall freezes both stages, opix_* hold stable.
//  - Bubble (ipix_valid=0, no stall) propagates as valid=0 in its slot; opix_Ex is don't-care when opix_valid=0.
//  - Rule gate: if B==H or D==F or bypass -> result = E for every sel.
//  - Scale2x (mode 0): sel0 B==D?D:E; sel1 B==F?F:E; sel2 H==D?D:E; sel3 H==F?F:E; sel 4..15 -> E.
//  - Scale3x (mode 1), eq(x,y)=x==y:
//    0: eq(D,B)?D:E   1: (eq(D,B)&E!=C)|(eq(B,F)&E!=A)?B:E   2: eq(B,F)?F:E
//    3: (eq(D,B)&E!=G)|(eq(D,H)&E!=A)?D:E   4: E   5: (eq(B,F)&E!=I)|(eq(H,F)&E!=C)?F:E
//    6: eq(D,H)?D:E   7: (eq(D,H)&E!=I)|(eq(H,F)&E!=G)?H:E   8: eq(H,F)?F:E   9..15 -> E
//  - Mode, sel, bypass sampled with the beat at acceptance (bypass sampled every accepted beat); mixing modes beat-to-beat is legal.
//  - stat_cnt: +1 when an output beat transfers (opix_valid & opix_ready) and selected source != E path.
//    Source selection, not value compare: result taken from D/F/B/H counts even if equal to E.
//    Saturates at all-ones. stat_clr has priority over increment in the same cycle (result 0).
//  - Reset mid-stream: in-flight beats discarded, no partial output; stat_cnt cleared.
// CONFIGURATION
//  GPU_SCALEX_3X_EN defined: Scale3x logic present, ipix_mode honoured, A/C/G/I compared.
//  GPU_SCALEX_3X_EN undefined: ipix_mode ignored (treated 0), ipix_A/C/G/I unused, sel 4..15 -> E; pipeline/latency unchanged.
// TESTING
//  T1 2x: B=D=5,E=7,F=3,H=2,sel0 -> opix_Ex=5 two cycles later, stat_cnt=1; same with sel1 -> 7.
//  T2 gate: B=H=4,D=5,E=7,F=3 all sel 0..3 -> 7; bypass=1 on T1 window -> 7, stat_cnt unchanged.
//  T3 3x: A=1,B=5,C=9,D=5,E=7,F=3,G=2,H=6,I=8 sel1 -> 5, sel3 -> 5, sel4 -> 7, sel8 -> 7 (3x_EN only).
//  T4 back-pressure: stream 8 beats, hold opix_ready=0 for 5 cycles mid-stream -> ipix_ready=0, outputs stable, no loss/dup, order kept.
//  T5 stat: CNT_W=4, 20 edge beats -> stat_cnt=15; stat_clr with concurrent edge beat -> 0.
//  T6 reset: rst_n=0 with 2 beats in flight -> opix_valid=0, stat_cnt=0 next cycle; no stale beat after release.

Source files
------------

// File: rtl/gpu_scalex_pipe.sv
// Scale2x/Scale3x sub-pixel engine: 2-stage valid/ready pipeline with a saturating edge-pixel counter.
// Scale3x rules are built only when GPU_SCALEX_3X_EN is defined; otherwise mode is forced to Scale2x.
module gpu_scalex_pipe #(
   parameter int PIX_W = 9,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bypass,
   input  logic             stat_clr,
   input  logic [PIX_W-1:0] ipix_A,
   input  logic [PIX_W-1:0] ipix_B,
   input  logic [PIX_W-1:0] ipix_C,
   input  logic [PIX_W-1:0] ipix_D,
   input  logic [PIX_W-1:0] ipix_E,
   input  logic [PIX_W-1:0] ipix_F,
   input  logic [PIX_W-1:0] ipix_G,
   input  logic [PIX_W-1:0] ipix_H,
   input  logic [PIX_W-1:0] ipix_I,
   input  logic [3:0]       ipix_sel,
   input  logic             ipix_mode,
   input  logic             ipix_valid,
   output logic             ipix_ready,
   output logic [PIX_W-1:0] opix_Ex,
   output logic [3:0]       opix_sel,
   output logic             opix_valid,
   input  logic             opix_ready,
   output logic [CNT_W-1:0] stat_cnt
);

   typedef enum logic [2:0] {
      SRC_E = 3'd0,
      SRC_B = 3'd1,
      SRC_D = 3'd2,
      SRC_F = 3'd3,
      SRC_H = 3'd4
   } src_e;

   logic             w_stall;
   logic             r1_valid;
   logic [3:0]       r1_sel;
   logic             r1_gate;
   logic             r1_eq_db;
   logic             r1_eq_bf;
   logic             r1_eq_dh;
   logic             r1_eq_hf;
   logic [PIX_W-1:0] r1_b;
   logic [PIX_W-1:0] r1_d;
   logic [PIX_W-1:0] r1_e;
   logic [PIX_W-1:0] r1_f;
   logic [PIX_W-1:0] r1_h;
   logic             r2_edge;
   src_e             w_src;
   logic [PIX_W-1:0] w_res;

   // A stalled output freezes the whole pipe, so the input side simply mirrors it.
   assign w_stall    = opix_valid & ~opix_ready;
   assign ipix_ready = ~w_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_sel   <= 4'd0;
         r1_gate  <= 1'b0;
         r1_eq_db <= 1'b0;
         r1_eq_bf <= 1'b0;
         r1_eq_dh <= 1'b0;
         r1_eq_hf <= 1'b0;
         r1_b     <= '0;
         r1_d     <= '0;
         r1_e     <= '0;
         r1_f     <= '0;
         r1_h     <= '0;
      end else if (!w_stall) begin
         r1_valid <= ipix_valid;
         r1_sel   <= ipix_sel;
         r1_gate  <= (ipix_B == ipix_H) | (ipix_D == ipix_F) | bypass;
         r1_eq_db <= (ipix_D == ipix_B);
         r1_eq_bf <= (ipix_B == ipix_F);
         r1_eq_dh <= (ipix_D == ipix_H);
         r1_eq_hf <= (ipix_H == ipix_F);
         r1_b     <= ipix_B;
         r1_d     <= ipix_D;
         r1_e     <= ipix_E;
         r1_f     <= ipix_F;
         r1_h     <= ipix_H;
      end
   end

`ifdef GPU_SCALEX_3X_EN
   logic r1_mode;
   logic r1_ne_ea;
   logic r1_ne_ec;
   logic r1_ne_eg;
   logic r1_ne_ei;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r1_mode  <= 1'b0;
         r1_ne_ea <= 1'b0;
         r1_ne_ec <= 1'b0;
         r1_ne_eg <= 1'b0;
         r1_ne_ei <= 1'b0;
      end else if (!w_stall) begin
         r1_mode  <= ipix_mode;
         r1_ne_ea <= (ipix_E != ipix_A);
         r1_ne_ec <= (ipix_E != ipix_C);
         r1_ne_eg <= (ipix_E != ipix_G);
         r1_ne_ei <= (ipix_E != ipix_I);
      end
   end
`else
   logic w_unused;
   assign w_unused = ^{ipix_A, ipix_C, ipix_G, ipix_I, ipix_mode};
`endif

   always_comb begin
      w_src = SRC_E;
      if (!r1_gate) begin
`ifdef GPU_SCALEX_3X_EN
         if (r1_mode) begin
            case (r1_sel)
               4'd0: if (r1_eq_db) w_src = SRC_D;
               4'd1: if ((r1_eq_db & r1_ne_ec) | (r1_eq_bf & r1_ne_ea)) w_src = SRC_B;
               4'd2: if (r1_eq_bf) w_src = SRC_F;
               4'd3: if ((r1_eq_db & r1_ne_eg) | (r1_eq_dh & r1_ne_ea)) w_src = SRC_D;
               4'd5: if ((r1_eq_bf & r1_ne_ei) | (r1_eq_hf & r1_ne_ec)) w_src = SRC_F;
               4'd6: if (r1_eq_dh) w_src = SRC_D;
               4'd7: if ((r1_eq_dh & r1_ne_ei) | (r1_eq_hf & r1_ne_eg)) w_src = SRC_H;
               4'd8: if (r1_eq_hf) w_src = SRC_F;
               default: w_src = SRC_E;
            endcase
         end else
`endif
         begin
            case (r1_sel)
               4'd0: if (r1_eq_db) w_src = SRC_D;
               4'd1: if (r1_eq_bf) w_src = SRC_F;
               4'd2: if (r1_eq_dh) w_src = SRC_D;
               4'd3: if (r1_eq_hf) w_src = SRC_F;
               default: w_src = SRC_E;
            endcase
         end
      end
   end

   always_comb begin
      w_res = r1_e;
      case (w_src)
         SRC_B:   w_res = r1_b;
         SRC_D:   w_res = r1_d;
         SRC_F:   w_res = r1_f;
         SRC_H:   w_res = r1_h;
         default: w_res = r1_e;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opix_valid <= 1'b0;
         opix_Ex    <= '0;
         opix_sel   <= 4'd0;
         r2_edge    <= 1'b0;
      end else if (!w_stall) begin
         opix_valid <= r1_valid;
         opix_Ex    <= w_res;
         opix_sel   <= r1_sel;
         r2_edge    <= (w_src != SRC_E);
      end
   end

   // Counts by chosen source, so a neighbour that happens to equal E still counts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_cnt <= '0;
      end else if (stat_clr) begin
         stat_cnt <= '0;
      end else if (opix_valid & opix_ready & r2_edge & ~(&stat_cnt)) begin
         stat_cnt <= stat_cnt + 1'b1;
      end
   end

endmodule
